// File: rtl/icetap_jtag_shift_regs_pkg.sv
// Shared icetap definitions: JTAG register selectors, CMD bit positions,
// STATUS field offsets and the DATA readout FSM state encoding.
package icetap_jtag_shift_regs_pkg;

    // Instruction-register values that select each icetap data register
    localparam logic [2:0] JTAG_REG_CMD          = 3'd0;
    localparam logic [2:0] JTAG_REG_STATUS       = 3'd1;
    localparam logic [2:0] JTAG_REG_STORE_MASK   = 3'd2;
    localparam logic [2:0] JTAG_REG_TRIGGER_MASK = 3'd3;
    localparam logic [2:0] JTAG_REG_DATA         = 3'd4;
    localparam logic [2:0] JTAG_REG_BYPASS       = 3'd7;

    // Bit positions inside a committed command word
    localparam int CMD_ARM        = 0;
    localparam int CMD_CLEAR      = 1;
    localparam int CMD_FORCE_TRIG = 2;

    // Field offsets inside the STATUS word presented by the capture core
    localparam int STATUS_ARMED      = 0;
    localparam int STATUS_TRIGGERED  = 1;
    localparam int STATUS_FULL       = 2;
    localparam int STATUS_WR_PTR_LSB = 8;

    // Sample-readout handshake states
    typedef enum logic {
        DATA_IDLE = 1'b0,
        DATA_WAIT = 1'b1
    } data_state_t;

endpackage

// File: rtl/icetap_shift_reg.sv
// Generic LSB-first JTAG shift register with a parallel load that takes
// priority over shifting. The register contents double as the parallel output.
module icetap_shift_reg
    import icetap_jtag_shift_regs_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             tck,
    input  logic             reset_,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_ena,
    input  logic             shift_in,
    output logic [WIDTH-1:0] q,
    output logic             shift_out
);

    logic [WIDTH-1:0] shifted;

    // A one-bit register simply takes the serial input on a shift
    if (WIDTH == 1) begin : g_single
        assign shifted = shift_in;
    end else begin : g_multi
        assign shifted = {shift_in, q[WIDTH-1:1]};
    end

    // Reset beats load, load beats shift
    always_ff @(posedge tck) begin
        if (!reset_) begin
            q <= RESET_VAL;
        end else if (load) begin
            q <= load_data;
        end else if (shift_ena) begin
            q <= shifted;
        end
    end

    assign shift_out = q[0];

endmodule

// File: rtl/icetap_jtag_shift_regs.sv
// Main-block (tck domain) end of the icetap JTAG register interface.
// Holds CMD, STATUS, STORE_MASK, TRIGGER_MASK and DATA shift registers.
// Optional build macro ICETAP_MASK_READBACK_EN adds serial readback of the
// old mask bits while a new mask is being shifted in.
module icetap_jtag_shift_regs
    import icetap_jtag_shift_regs_pkg::*;
#(
    parameter int NR_SIGNALS  = 1,
    parameter int CMD_BITS    = 8,
    parameter int STATUS_BITS = 16
) (
    input  logic                   tck,
    input  logic                   reset_,
    input  logic                   cmd_shift_ena,
    input  logic                   cmd_shift_update,
    input  logic                   cmd_shift_data,
    output logic [CMD_BITS-1:0]    cmd_word,
    output logic                   cmd_valid,
    input  logic                   status_shift_update,
    input  logic                   status_shift_ena,
    output logic                   status_shift_data,
    input  logic [STATUS_BITS-1:0] status_in,
    input  logic                   store_mask_shift_ena,
    input  logic                   store_mask_shift_data,
    output logic [NR_SIGNALS-1:0]  store_mask,
    input  logic                   trigger_mask_shift_ena,
    input  logic                   trigger_mask_shift_data,
    output logic [NR_SIGNALS-1:0]  trigger_mask,
    input  logic                   data_shift_update,
    input  logic                   data_shift_ena,
    output logic                   data_shift_data,
    output logic                   data_rd_req,
    input  logic                   data_rd_valid,
    input  logic [NR_SIGNALS-1:0]  data_rd_data,
    output logic                   data_rd_busy
`ifdef ICETAP_MASK_READBACK_EN
    ,
    output logic                   store_mask_shift_out,
    output logic                   trigger_mask_shift_out
`endif
);

    logic [CMD_BITS-1:0] cmd_sr;
    logic                cmd_sr_unused_out;
    data_state_t         data_state;
    data_state_t         data_state_next;
    logic                data_rd_req_next;
    logic                data_load;

`ifndef ICETAP_MASK_READBACK_EN
    logic store_mask_unused_out;
    logic trigger_mask_unused_out;
`endif

    // CMD shift register; an update in the same cycle freezes it so the
    // committed word is the pre-shift value
    icetap_shift_reg #(
        .WIDTH     (CMD_BITS),
        .RESET_VAL ('0)
    ) u_cmd_sr (
        .tck       (tck),
        .reset_    (reset_),
        .load      (1'b0),
        .load_data ('0),
        .shift_ena (cmd_shift_ena & ~cmd_shift_update),
        .shift_in  (cmd_shift_data),
        .q         (cmd_sr),
        .shift_out (cmd_sr_unused_out)
    );

    // Commit the shifted command and flag it for exactly one cycle
    always_ff @(posedge tck) begin
        if (!reset_) begin
            cmd_word  <= '0;
            cmd_valid <= 1'b0;
        end else begin
            cmd_valid <= cmd_shift_update;
            if (cmd_shift_update) begin
                cmd_word <= cmd_sr;
            end
        end
    end

    // STATUS: capture the core's status word, then drain it LSB first
    icetap_shift_reg #(
        .WIDTH     (STATUS_BITS),
        .RESET_VAL ('0)
    ) u_status_sr (
        .tck       (tck),
        .reset_    (reset_),
        .load      (status_shift_update),
        .load_data (status_in),
        .shift_ena (status_shift_ena),
        .shift_in  (1'b0),
        .q         (),
        .shift_out (status_shift_data)
    );

    // Store mask is live while shifting; reset keeps every signal stored
    icetap_shift_reg #(
        .WIDTH     (NR_SIGNALS),
        .RESET_VAL ({NR_SIGNALS{1'b1}})
    ) u_store_mask_sr (
        .tck       (tck),
        .reset_    (reset_),
        .load      (1'b0),
        .load_data ('0),
        .shift_ena (store_mask_shift_ena),
        .shift_in  (store_mask_shift_data),
        .q         (store_mask),
`ifdef ICETAP_MASK_READBACK_EN
        .shift_out (store_mask_shift_out)
`else
        .shift_out (store_mask_unused_out)
`endif
    );

    // Trigger mask is live while shifting; reset disables all triggers
    icetap_shift_reg #(
        .WIDTH     (NR_SIGNALS),
        .RESET_VAL ('0)
    ) u_trigger_mask_sr (
        .tck       (tck),
        .reset_    (reset_),
        .load      (1'b0),
        .load_data ('0),
        .shift_ena (trigger_mask_shift_ena),
        .shift_in  (trigger_mask_shift_data),
        .q         (trigger_mask),
`ifdef ICETAP_MASK_READBACK_EN
        .shift_out (trigger_mask_shift_out)
`else
        .shift_out (trigger_mask_unused_out)
`endif
    );

    // DATA: loaded from sample memory when a read completes, then drained
    icetap_shift_reg #(
        .WIDTH     (NR_SIGNALS),
        .RESET_VAL ('0)
    ) u_data_sr (
        .tck       (tck),
        .reset_    (reset_),
        .load      (data_load),
        .load_data (data_rd_data),
        .shift_ena (data_shift_ena),
        .shift_in  (1'b0),
        .q         (),
        .shift_out (data_shift_data)
    );

    // Readout FSM state and the registered one-cycle request pulse
    always_ff @(posedge tck) begin
        if (!reset_) begin
            data_state  <= DATA_IDLE;
            data_rd_req <= 1'b0;
        end else begin
            data_state  <= data_state_next;
            data_rd_req <= data_rd_req_next;
        end
    end

    // Issue one request per idle update; accept the reply only while waiting
    always_comb begin
        data_state_next  = data_state;
        data_rd_req_next = 1'b0;
        data_load        = 1'b0;
        case (data_state)
            DATA_IDLE: begin
                if (data_shift_update) begin
                    data_state_next  = DATA_WAIT;
                    data_rd_req_next = 1'b1;
                end
            end
            DATA_WAIT: begin
                if (data_rd_valid) begin
                    data_load       = 1'b1;
                    data_state_next = DATA_IDLE;
                end
            end
            default: begin
                data_state_next = DATA_IDLE;
            end
        endcase
    end

    assign data_rd_busy = (data_state == DATA_WAIT);

endmodule

// File: tb/tb_icetap_jtag_shift_regs.sv
// Directed self-checking bench for icetap_jtag_shift_regs (NR_SIGNALS=4).
module tb_icetap_jtag_shift_regs;

    localparam int NR_SIGNALS  = 4;
    localparam int CMD_BITS    = 8;
    localparam int STATUS_BITS = 16;

    logic                   tck = 1'b0;
    logic                   reset_ = 1'b0;
    logic                   cmd_shift_ena = 1'b0;
    logic                   cmd_shift_update = 1'b0;
    logic                   cmd_shift_data = 1'b0;
    logic [CMD_BITS-1:0]    cmd_word;
    logic                   cmd_valid;
    logic                   status_shift_update = 1'b0;
    logic                   status_shift_ena = 1'b0;
    logic                   status_shift_data;
    logic [STATUS_BITS-1:0] status_in = '0;
    logic                   store_mask_shift_ena = 1'b0;
    logic                   store_mask_shift_data = 1'b0;
    logic [NR_SIGNALS-1:0]  store_mask;
    logic                   trigger_mask_shift_ena = 1'b0;
    logic                   trigger_mask_shift_data = 1'b0;
    logic [NR_SIGNALS-1:0]  trigger_mask;
    logic                   data_shift_update = 1'b0;
    logic                   data_shift_ena = 1'b0;
    logic                   data_shift_data;
    logic                   data_rd_req;
    logic                   data_rd_valid = 1'b0;
    logic [NR_SIGNALS-1:0]  data_rd_data = '0;
    logic                   data_rd_busy;
`ifdef ICETAP_MASK_READBACK_EN
    logic                   store_mask_shift_out;
    logic                   trigger_mask_shift_out;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;

    icetap_jtag_shift_regs #(
        .NR_SIGNALS  (NR_SIGNALS),
        .CMD_BITS    (CMD_BITS),
        .STATUS_BITS (STATUS_BITS)
    ) dut (
        .tck                     (tck),
        .reset_                  (reset_),
        .cmd_shift_ena           (cmd_shift_ena),
        .cmd_shift_update        (cmd_shift_update),
        .cmd_shift_data          (cmd_shift_data),
        .cmd_word                (cmd_word),
        .cmd_valid               (cmd_valid),
        .status_shift_update     (status_shift_update),
        .status_shift_ena        (status_shift_ena),
        .status_shift_data       (status_shift_data),
        .status_in               (status_in),
        .store_mask_shift_ena    (store_mask_shift_ena),
        .store_mask_shift_data   (store_mask_shift_data),
        .store_mask              (store_mask),
        .trigger_mask_shift_ena  (trigger_mask_shift_ena),
        .trigger_mask_shift_data (trigger_mask_shift_data),
        .trigger_mask            (trigger_mask),
        .data_shift_update       (data_shift_update),
        .data_shift_ena          (data_shift_ena),
        .data_shift_data         (data_shift_data),
        .data_rd_req             (data_rd_req),
        .data_rd_valid           (data_rd_valid),
        .data_rd_data            (data_rd_data),
        .data_rd_busy            (data_rd_busy)
`ifdef ICETAP_MASK_READBACK_EN
        ,
        .store_mask_shift_out    (store_mask_shift_out),
        .trigger_mask_shift_out  (trigger_mask_shift_out)
`endif
    );

    // 100 MHz-style free-running tck
    always #5 tck = ~tck;

    // Advance one clock; inputs are changed and outputs sampled 1 after the edge
    task automatic tick();
        @(posedge tck);
        #1;
    endtask

    task automatic test_reset();
        reset_ = 1'b0;
        tick();
        tick();
        reset_ = 1'b1;
        n_compared++;
        if (cmd_word !== 8'h00) begin n_mismatched++; $display("FAIL reset_cmd_word got %h want 00", cmd_word); end
        n_compared++;
        if (cmd_valid !== 1'b0) begin n_mismatched++; $display("FAIL reset_cmd_valid got %b want 0", cmd_valid); end
        n_compared++;
        if (status_shift_data !== 1'b0) begin n_mismatched++; $display("FAIL reset_status got %b want 0", status_shift_data); end
        n_compared++;
        if (store_mask !== 4'hF) begin n_mismatched++; $display("FAIL reset_store_mask got %h want F", store_mask); end
        n_compared++;
        if (trigger_mask !== 4'h0) begin n_mismatched++; $display("FAIL reset_trigger_mask got %h want 0", trigger_mask); end
        n_compared++;
        if (data_shift_data !== 1'b0) begin n_mismatched++; $display("FAIL reset_data got %b want 0", data_shift_data); end
        n_compared++;
        if (data_rd_req !== 1'b0 || data_rd_busy !== 1'b0) begin
            n_mismatched++; $display("FAIL reset_rd got req=%b busy=%b want 0 0", data_rd_req, data_rd_busy);
        end
    endtask

    task automatic test_cmd();
        int bits_a [8] = '{1, 0, 1, 0, 0, 0, 0, 0};
        int bits_b [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
        for (int i = 0; i < 8; i++) begin
            cmd_shift_ena  = 1'b1;
            cmd_shift_data = bits_a[i][0];
            tick();
        end
        cmd_shift_ena    = 1'b0;
        cmd_shift_update = 1'b1;
        tick();
        cmd_shift_update = 1'b0;
        n_compared++;
        if (cmd_word !== 8'h05) begin n_mismatched++; $display("FAIL cmd_word got %h want 05", cmd_word); end
        n_compared++;
        if (cmd_valid !== 1'b1) begin n_mismatched++; $display("FAIL cmd_valid_pulse got %b want 1", cmd_valid); end
        tick();
        n_compared++;
        if (cmd_valid !== 1'b0) begin n_mismatched++; $display("FAIL cmd_valid_end got %b want 0", cmd_valid); end
        // Back-to-back updates give back-to-back pulses
        cmd_shift_update = 1'b1;
        tick();
        n_compared++;
        if (cmd_valid !== 1'b1) begin n_mismatched++; $display("FAIL cmd_b2b_first got %b want 1", cmd_valid); end
        tick();
        cmd_shift_update = 1'b0;
        n_compared++;
        if (cmd_valid !== 1'b1) begin n_mismatched++; $display("FAIL cmd_b2b_second got %b want 1", cmd_valid); end
        tick();
        n_compared++;
        if (cmd_valid !== 1'b0) begin n_mismatched++; $display("FAIL cmd_b2b_end got %b want 0", cmd_valid); end
        // Load F0 into the shift register without committing
        for (int i = 0; i < 8; i++) begin
            cmd_shift_ena  = 1'b1;
            cmd_shift_data = bits_b[i][0];
            tick();
        end
        n_compared++;
        if (cmd_word !== 8'h05) begin n_mismatched++; $display("FAIL cmd_hold got %h want 05", cmd_word); end
        // Shift and update together: the pre-shift F0 must be committed
        cmd_shift_ena    = 1'b1;
        cmd_shift_data   = 1'b1;
        cmd_shift_update = 1'b1;
        tick();
        cmd_shift_ena    = 1'b0;
        cmd_shift_update = 1'b0;
        n_compared++;
        if (cmd_word !== 8'hF0) begin n_mismatched++; $display("FAIL cmd_shift_and_update got %h want F0", cmd_word); end
    endtask

    task automatic test_status();
        int exp_bits [16] = '{1, 1, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 1, 0, 1};
        status_in           = 16'hA5C3;
        status_shift_update = 1'b1;
        tick();
        status_shift_update = 1'b0;
        for (int i = 0; i < 16; i++) begin
            n_compared++;
            if (status_shift_data !== exp_bits[i][0]) begin
                n_mismatched++;
                $display("FAIL status_bit%0d got %b want %0d", i, status_shift_data, exp_bits[i]);
            end
            status_shift_ena = 1'b1;
            tick();
        end
        n_compared++;
        if (status_shift_data !== 1'b0) begin n_mismatched++; $display("FAIL status_drained got %b want 0", status_shift_data); end
        tick();
        n_compared++;
        if (status_shift_data !== 1'b0) begin n_mismatched++; $display("FAIL status_drained2 got %b want 0", status_shift_data); end
        // Capture and shift together: capture wins (register was empty)
        status_in           = 16'h0001;
        status_shift_update = 1'b1;
        status_shift_ena    = 1'b1;
        tick();
        status_shift_update = 1'b0;
        n_compared++;
        if (status_shift_data !== 1'b1) begin n_mismatched++; $display("FAIL status_capture_wins got %b want 1", status_shift_data); end
        tick();
        status_shift_ena = 1'b0;
        n_compared++;
        if (status_shift_data !== 1'b0) begin n_mismatched++; $display("FAIL status_after_capture got %b want 0", status_shift_data); end
    endtask

    task automatic test_masks();
        int trig_bits  [4] = '{1, 1, 0, 0};
        int store_bits [4] = '{0, 1, 0, 1};
        trigger_mask_shift_ena  = 1'b1;
        trigger_mask_shift_data = 1'b1;
        tick();
        n_compared++;
        if (trigger_mask !== 4'h8) begin n_mismatched++; $display("FAIL trigger_live got %h want 8", trigger_mask); end
        for (int i = 1; i < 4; i++) begin
            trigger_mask_shift_data = trig_bits[i][0];
            tick();
        end
        trigger_mask_shift_ena = 1'b0;
        n_compared++;
        if (trigger_mask !== 4'h3) begin n_mismatched++; $display("FAIL trigger_mask got %h want 3", trigger_mask); end
        n_compared++;
        if (store_mask !== 4'hF) begin n_mismatched++; $display("FAIL store_untouched got %h want F", store_mask); end
        for (int i = 0; i < 4; i++) begin
            store_mask_shift_ena  = 1'b1;
            store_mask_shift_data = store_bits[i][0];
            tick();
        end
        store_mask_shift_ena  = 1'b0;
        store_mask_shift_data = 1'b1;
        tick();
        n_compared++;
        if (store_mask !== 4'hA) begin n_mismatched++; $display("FAIL store_mask got %h want A", store_mask); end
        n_compared++;
        if (trigger_mask !== 4'h3) begin n_mismatched++; $display("FAIL trigger_hold got %h want 3", trigger_mask); end
    endtask

`ifdef ICETAP_MASK_READBACK_EN
    task automatic test_readback();
        int exp_old [4] = '{0, 1, 0, 1};
        for (int i = 0; i < 4; i++) begin
            n_compared++;
            if (store_mask_shift_out !== exp_old[i][0]) begin
                n_mismatched++;
                $display("FAIL readback_bit%0d got %b want %0d", i, store_mask_shift_out, exp_old[i]);
            end
            store_mask_shift_ena  = 1'b1;
            store_mask_shift_data = 1'b1;
            tick();
        end
        store_mask_shift_ena = 1'b0;
        n_compared++;
        if (store_mask !== 4'hF) begin n_mismatched++; $display("FAIL readback_new_mask got %h want F", store_mask); end
        n_compared++;
        if (trigger_mask_shift_out !== 1'b1) begin n_mismatched++; $display("FAIL trigger_readback got %b want 1", trigger_mask_shift_out); end
    endtask
`endif

    task automatic test_data();
        int exp_bits [4] = '{1, 0, 0, 1};
        data_shift_update = 1'b1;
        tick();
        n_compared++;
        if (data_rd_req !== 1'b1 || data_rd_busy !== 1'b1) begin
            n_mismatched++; $display("FAIL data_req got req=%b busy=%b want 1 1", data_rd_req, data_rd_busy);
        end
        // Update again while busy: no second request
        tick();
        data_shift_update = 1'b0;
        n_compared++;
        if (data_rd_req !== 1'b0 || data_rd_busy !== 1'b1) begin
            n_mismatched++; $display("FAIL data_busy_update got req=%b busy=%b want 0 1", data_rd_req, data_rd_busy);
        end
        tick();
        data_rd_valid = 1'b1;
        data_rd_data  = 4'h9;
        tick();
        data_rd_valid = 1'b0;
        data_rd_data  = 4'h0;
        n_compared++;
        if (data_rd_busy !== 1'b0) begin n_mismatched++; $display("FAIL data_busy_clear got %b want 0", data_rd_busy); end
        for (int i = 0; i < 4; i++) begin
            n_compared++;
            if (data_shift_data !== exp_bits[i][0]) begin
                n_mismatched++;
                $display("FAIL data_bit%0d got %b want %0d", i, data_shift_data, exp_bits[i]);
            end
            data_shift_ena = 1'b1;
            tick();
        end
        data_shift_ena = 1'b0;
        n_compared++;
        if (data_shift_data !== 1'b0) begin n_mismatched++; $display("FAIL data_drained got %b want 0", data_shift_data); end
        // Valid while idle must be ignored
        data_rd_valid = 1'b1;
        data_rd_data  = 4'hF;
        tick();
        data_rd_valid = 1'b0;
        n_compared++;
        if (data_shift_data !== 1'b0 || data_rd_busy !== 1'b0) begin
            n_mismatched++; $display("FAIL data_idle_valid got data=%b busy=%b want 0 0", data_shift_data, data_rd_busy);
        end
        // Minimum latency with a concurrent shift: load of 6 wins
        data_shift_update = 1'b1;
        tick();
        data_shift_update = 1'b0;
        data_rd_valid     = 1'b1;
        data_rd_data      = 4'h6;
        data_shift_ena    = 1'b1;
        tick();
        data_rd_valid = 1'b0;
        data_rd_data  = 4'h0;
        n_compared++;
        if (data_shift_data !== 1'b0 || data_rd_busy !== 1'b0) begin
            n_mismatched++; $display("FAIL data_fast_load got data=%b busy=%b want 0 0", data_shift_data, data_rd_busy);
        end
        tick();
        data_shift_ena = 1'b0;
        n_compared++;
        if (data_shift_data !== 1'b1) begin n_mismatched++; $display("FAIL data_fast_shift got %b want 1", data_shift_data); end
    endtask

    task automatic test_reset_in_wait();
        data_shift_update = 1'b1;
        tick();
        data_shift_update = 1'b0;
        n_compared++;
        if (data_rd_busy !== 1'b1) begin n_mismatched++; $display("FAIL wait_entered got %b want 1", data_rd_busy); end
        reset_ = 1'b0;
        tick();
        reset_ = 1'b1;
        n_compared++;
        if (data_rd_busy !== 1'b0 || data_rd_req !== 1'b0) begin
            n_mismatched++; $display("FAIL wait_reset got busy=%b req=%b want 0 0", data_rd_busy, data_rd_req);
        end
        data_rd_valid = 1'b1;
        data_rd_data  = 4'hF;
        tick();
        data_rd_valid = 1'b0;
        n_compared++;
        if (data_shift_data !== 1'b0 || data_rd_busy !== 1'b0) begin
            n_mismatched++; $display("FAIL late_valid got data=%b busy=%b want 0 0", data_shift_data, data_rd_busy);
        end
        n_compared++;
        if (store_mask !== 4'hF || cmd_word !== 8'h00) begin
            n_mismatched++; $display("FAIL reset_regs got store=%h cmd=%h want F 00", store_mask, cmd_word);
        end
    endtask

    // Run every scenario in order, then report
    initial begin
        test_reset();
        test_cmd();
        test_status();
        test_masks();
`ifdef ICETAP_MASK_READBACK_EN
        test_readback();
`endif
        test_data();
        test_reset_in_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/icetap_jtag_shift_regs.md
Name: icetap_jtag_shift_regs

Overview:
- Main-block end of the icetap JTAG register interface, in the tck domain.
- Consumes the per-register shift_ena / shift_data / update strobes produced by the JTAG register decoder.
- Holds the CMD, STATUS, STORE_MASK, TRIGGER_MASK and DATA shift registers.
- Presents parallel command words, masks and sample-readout requests to the capture core, and returns serial status/data bits for TDO.

Parameters:
- NR_SIGNALS, 1, number of probed signals; width of the masks and of a DATA sample word.
- CMD_BITS, 8, width of the CMD register.
- STATUS_BITS, 16, width of the STATUS register.

Ports:
- tck  in  1  JTAG clock, sole clock.
- reset_  in  1  synchronous, active-low reset.
- cmd_shift_ena  in  1  shift CMD register one bit.
- cmd_shift_update  in  1  commit shifted CMD word.
- cmd_shift_data  in  1  serial CMD bit (TDI).
- cmd_word  out  CMD_BITS  last committed command.
- cmd_valid  out  1  one-cycle pulse when cmd_word is committed.
- status_shift_update  in  1  capture status_in into the STATUS shift register.
- status_shift_ena  in  1  shift STATUS one bit.
- status_shift_data  out  1  serial STATUS bit.
- status_in  in  STATUS_BITS  parallel status from the core.
- store_mask_shift_ena  in  1  shift STORE_MASK.
- store_mask_shift_data  in  1  serial STORE_MASK bit.
- store_mask  out  NR_SIGNALS  current store mask.
- trigger_mask_shift_ena  in  1  shift TRIGGER_MASK.
- trigger_mask_shift_data  in  1  serial TRIGGER_MASK bit.
- trigger_mask  out  NR_SIGNALS  current trigger mask.
- data_shift_update  in  1  request the next sample word.
- data_shift_ena  in  1  shift DATA one bit.
- data_shift_data  out  1  serial DATA bit.
- data_rd_req  out  1  one-cycle request to the sample memory.
- data_rd_valid  in  1  data_rd_data is valid this cycle.
- data_rd_data  in  NR_SIGNALS  sample word from memory.
- data_rd_busy  out  1  request outstanding.

Behaviour:
- All registers update on posedge tck. Reset (reset_ low at an edge) overrides every other event that cycle.
- Reset values: cmd_sr=0, cmd_word=0, cmd_valid=0, status_sr=0, store_mask=all ones, trigger_mask=0, data_sr=0, data_rd_req=0, data_rd_busy=0.
- Shift convention (every register): LSB leaves first. Shift is reg <= {serial_in, reg[W-1:1]}.
- CMD:
  - cmd_shift_ena shifts cmd_shift_data into cmd_sr.
  - cmd_shift_update: cmd_word <= cmd_sr; cmd_valid=1 on the next cycle only.
  - If shift and update occur in the same cycle, update wins and uses the pre-shift cmd_sr.
  - Back-to-back updates produce back-to-back pulses.
- STATUS:
  - status_shift_update loads status_sr <= status_in.
  - status_shift_ena shifts with 0 inserted at the MSB.
  - status_shift_data = status_sr[0], combinational.
  - Capture and shift in the same cycle: capture wins.
- Masks:
  - The shift registers are the outputs themselves; they are live during shifting, with no separate update.
  - After NR_SIGNALS shifts, the mask equals the last NR_SIGNALS bits; the first-shifted bit lands in bit 0.
- DATA, two-state FSM IDLE/WAIT:
  - IDLE, data_shift_update: pulse data_rd_req for 1 cycle, go to WAIT, data_rd_busy=1.
  - WAIT, data_rd_valid: data_sr <= data_rd_data, go to IDLE, data_rd_busy=0.
  - data_shift_update while in WAIT is ignored (no second request).
  - data_rd_valid while in IDLE is ignored.
  - data_shift_ena shifts with 0 inserted at the MSB; it is ignored in a cycle where a load occurs.
  - data_shift_data = data_sr[0].
  - Minimum latency from update to load is 1 cycle (memory may return valid the cycle after the request).
- Reset mid-WAIT returns the FSM to IDLE; a late data_rd_valid is then ignored.

Optional Feature:
- ICETAP_MASK_READBACK_EN defined:
  - Adds outputs store_mask_shift_out and trigger_mask_shift_out, each equal to bit 0 of the respective mask before the shift.
  - The host can read the old mask while writing the new one.
- Undefined: these ports do not exist, and there is no readback.

Decomposition:
- Shared icetap defines header holds:
  - the JTAG_REG_* register selectors;
  - the CMD bit assignments (CMD_ARM=bit0, CMD_CLEAR=bit1, CMD_FORCE_TRIG=bit2);
  - the STATUS field offsets;
  - the DATA FSM state encodings.
- One natural sub-module: icetap_shift_reg (parameter WIDTH, RESET_VAL; ports load, load_data, shift_ena, shift_in, q, shift_out). It is instantiated for CMD, STATUS, both masks and DATA.

Test Plan:
- CMD: shift 8 bits 1,0,1,0,0,0,0,0 then update -> cmd_word=8'h05, cmd_valid high for exactly 1 cycle.
- STATUS: status_in=16'hA5C3, capture, then 16 shifts -> serial out 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; further shifts -> 0.
- Masks (NR_SIGNALS=4): after reset store_mask=4'hF, trigger_mask=0. Shift 1,1,0,0 into trigger -> trigger_mask=4'h3.
- DATA: update -> data_rd_req 1-cycle pulse. Second update while busy -> no req. Valid with 4'h9 after 3 cycles -> shift out 1,0,0,1.
- Reset in WAIT, then data_rd_valid -> data_sr stays 0, busy=0. Also CMD shift+update in the same cycle -> commit uses pre-shift value.
- ICETAP_MASK_READBACK_EN: preload store_mask=4'hA, shift 4 new bits -> store_mask_shift_out shows 0,1,0,1.
